instqueue: RTL and testbench
============================

Name: instqueue

Overview:
- Circular FIFO between instruction fetch and the combinational decoder.
- Buffers fetched (instruction, pc) pairs and presents at most one head entry per cycle to the decoder.
- Pops the head only when the dispatcher is not stalled.
- Flushes on a decoder JAL redirect or a ROB misprediction; this sequences the whole decode/dispatch front-end.

Parameters:
- DEPTH, 16, number of entries (power of two).
- PTR_WIDTH, 4, log2(DEPTH).
- IDWidth, 32, instruction width.
- AddressWidth, 32, pc width.

Ports:
- clk_in  input  1  clock, all state updates on rising edge.
- rst_in  input  1  asynchronous active-high reset.
- rdy_in  input  1  global ready; when low, the block holds all state.
- if_instqueue_en_in  input  1  fetch pushes an entry this cycle.
- if_instqueue_inst_in  input  IDWidth  pushed instruction.
- if_instqueue_pc_in  input  AddressWidth  pushed pc.
- instqueue_if_full_out  output  1  queue holds DEPTH entries; fetch must not push.
- dispatcher_instqueue_stall_in  input  1  dispatcher cannot accept this cycle.
- decoder_instqueue_rst_in  input  1  JAL redirect flush from decoder.
- rob_instqueue_rst_in  input  1  misprediction flush from ROB.
- instqueue_decoder_en_out  output  1  head entry valid and consumed this cycle.
- instqueue_decoder_inst_out  output  IDWidth  head instruction.
- instqueue_decoder_pc_out  output  AddressWidth  head pc.
- instqueue_count_out  output  PTR_WIDTH+1  current occupancy.

Behaviour:
- State: storage arrays inst[DEPTH], pc[DEPTH]; head and tail pointers (PTR_WIDTH bits); count (PTR_WIDTH+1 bits).
- Reset (async, rst_in high): head=0, tail=0, count=0. Storage contents don't-care.
- Outputs during reset: en_out=0, inst_out=0, pc_out=0, full_out=0, count_out=0.
- count_out = count. full_out = (count==DEPTH). Both are derived from registers only.
- en_out = rdy_in & !rst_in & (count!=0) & !dispatcher_instqueue_stall_in & !rob_instqueue_rst_in. Purely combinational.
- en_out must NOT depend on decoder_instqueue_rst_in. The decoder derives that flush from en_out, so a dependency would form a combinational loop.
- inst_out/pc_out = inst[head]/pc[head] when en_out, else 0.
- Pop: on a clock edge where en_out=1, head<=head+1 (mod DEPTH). Latency: a pushed entry is visible at the head no earlier than the cycle after the push (no bypass).
- Push: accepted when rdy_in & if_instqueue_en_in & (count<DEPTH) & no flush this cycle. It writes inst[tail]/pc[tail] and sets tail<=tail+1 (mod DEPTH).
- Push while full: dropped silently, even if a pop happens the same cycle. Full is judged on the pre-edge count.
- Simultaneous push and pop (no flush): count unchanged; head and tail both advance.
- Pointer wrap-around: DEPTH-1 -> 0. count distinguishes full from empty.
- ROB flush (rob_instqueue_rst_in=1, rdy_in=1): next edge sets head=tail=count=0. No pop that cycle (en_out forced 0) and the same-cycle push is dropped. ROB flush has priority over everything.
- Decoder flush (decoder_instqueue_rst_in=1, rdy_in=1, no ROB flush): the current head (the JAL) is still consumed, because en_out remains 1. The next edge sets head=tail=count=0 and the same-cycle push is dropped.
- rdy_in low: no push, no pop, no flush takes effect; en_out=0; all registers hold.
- Reset asserted mid-operation: immediate clear; entries are lost and en_out drops in the same cycle.

Test Plan:
- Reset, then push pc 0x0..0x1C (8 words, inst 0x00000013) with stall=0 -> en_out rises one cycle after the first push. Entries appear in order pc 0x0,0x4,...,0x1C, one per cycle. count_out returns to 0.
- Stall held high, push 16 entries -> full_out=1 and count_out=16. A 17th push (pc 0x40) is dropped. Release stall -> exactly 16 pops and pc 0x40 never appears.
- Full queue, stall=0, push and pop in the same cycle -> pop occurs, push dropped, count_out=15.
- Full/empty cycling 40 entries through DEPTH=16 -> pointers wrap. Output order and pcs match input, with no duplicates or losses.
- Queue holds 5 entries, head is JAL (inst 0x0080006F, pc 0x100), decoder flush asserted while en_out=1 -> JAL is consumed with pc_out=0x100. Next cycle count_out=0 and en_out=0. A same-cycle push is absent.
- 6 entries queued, ROB flush with stall=0 -> en_out=0 that cycle, then count_out=0. Asserting rdy_in=0 for 3 cycles with pushes pending -> count_out unchanged and en_out=0. Asserting rst_in mid-stream -> all outputs go to 0 immediately.

Source files
------------

// File: rtl/instqueue_if.sv
// Fetch/decode-side bundle of the instruction queue.
// slave: queue side; master: fetch, dispatcher, decoder, ROB side.
interface instqueue_if #(
  parameter int PTR_WIDTH    = 4,
  parameter int IDWidth      = 32,
  parameter int AddressWidth = 32
);
  logic                    if_instqueue_en_in;
  logic [IDWidth-1:0]      if_instqueue_inst_in;
  logic [AddressWidth-1:0] if_instqueue_pc_in;
  logic                    instqueue_if_full_out;
  logic                    dispatcher_instqueue_stall_in;
  logic                    decoder_instqueue_rst_in;
  logic                    rob_instqueue_rst_in;
  logic                    instqueue_decoder_en_out;
  logic [IDWidth-1:0]      instqueue_decoder_inst_out;
  logic [AddressWidth-1:0] instqueue_decoder_pc_out;
  logic [PTR_WIDTH:0]      instqueue_count_out;

  modport slave (
    input  if_instqueue_en_in,
    input  if_instqueue_inst_in,
    input  if_instqueue_pc_in,
    output instqueue_if_full_out,
    input  dispatcher_instqueue_stall_in,
    input  decoder_instqueue_rst_in,
    input  rob_instqueue_rst_in,
    output instqueue_decoder_en_out,
    output instqueue_decoder_inst_out,
    output instqueue_decoder_pc_out,
    output instqueue_count_out
  );

  modport master (
    output if_instqueue_en_in,
    output if_instqueue_inst_in,
    output if_instqueue_pc_in,
    input  instqueue_if_full_out,
    output dispatcher_instqueue_stall_in,
    output decoder_instqueue_rst_in,
    output rob_instqueue_rst_in,
    input  instqueue_decoder_en_out,
    input  instqueue_decoder_inst_out,
    input  instqueue_decoder_pc_out,
    input  instqueue_count_out
  );
endinterface

// File: rtl/instqueue.sv
// Circular (inst, pc) FIFO between fetch and decoder; flushable.
// Ports: clk_in, rst_in (async high), rdy_in, q (instqueue_if.slave).
module instqueue #(
  parameter int DEPTH        = 16,
  parameter int PTR_WIDTH    = 4,
  parameter int IDWidth      = 32,
  parameter int AddressWidth = 32
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  instqueue_if.slave  q
);
  localparam logic [PTR_WIDTH:0] FULL_CNT =
    (PTR_WIDTH+1)'(DEPTH);

  logic [IDWidth-1:0]      inst_mem [DEPTH];
  logic [AddressWidth-1:0] pc_mem   [DEPTH];
  logic [PTR_WIDTH-1:0]    head;
  logic [PTR_WIDTH-1:0]    tail;
  logic [PTR_WIDTH:0]      count;

  logic full;
  logic pop;
  logic flush;
  logic push;

  assign full = (count == FULL_CNT);

  // Decoder flush is deliberately absent: the decoder
  // derives it from en_out, so it must still pop the JAL.
  assign pop = rdy_in & ~rst_in
             & (count != '0)
             & ~q.dispatcher_instqueue_stall_in
             & ~q.rob_instqueue_rst_in;

  assign flush = q.rob_instqueue_rst_in
               | q.decoder_instqueue_rst_in;

  // Full is judged before the edge; a same-cycle pop
  // does not make room.
  assign push = rdy_in & q.if_instqueue_en_in
              & ~full & ~flush;

  assign q.instqueue_if_full_out    = full;
  assign q.instqueue_count_out      = count;
  assign q.instqueue_decoder_en_out = pop;
  assign q.instqueue_decoder_inst_out =
    pop ? inst_mem[head] : '0;
  assign q.instqueue_decoder_pc_out =
    pop ? pc_mem[head] : '0;

  always_ff @(posedge clk_in) begin
    if (push) begin
      inst_mem[tail] <= q.if_instqueue_inst_in;
      pc_mem[tail]   <= q.if_instqueue_pc_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_instqueue.sv
// Scoreboard bench for instqueue: expected entries queued on
// accepted pushes, popped and compared on each DUT pop.
module tb_instqueue;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  instqueue_if #(.PTR_WIDTH(4), .IDWidth(32),
    .AddressWidth(32)) ifc ();

  instqueue #(.DEPTH(DEPTH), .PTR_WIDTH(4),
    .IDWidth(32), .AddressWidth(32)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .q      (ifc.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  logic [63:0] sb [$];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: check outputs at negedge, update scoreboard.
  task automatic cyc();
    logic exp_en;
    logic full_pre;
    @(negedge clk);
    full_pre = (sb.size() == DEPTH);
    exp_en = rdy && sb.size() != 0
           && !ifc.dispatcher_instqueue_stall_in
           && !ifc.rob_instqueue_rst_in;
    chk("en", ifc.instqueue_decoder_en_out, exp_en);
    chk("count", ifc.instqueue_count_out, sb.size());
    chk("full", ifc.instqueue_if_full_out, full_pre);
    if (ifc.instqueue_decoder_en_out) pops++;
    if (exp_en) begin
      chk("inst", ifc.instqueue_decoder_inst_out,
          sb[0][63:32]);
      chk("pc", ifc.instqueue_decoder_pc_out, sb[0][31:0]);
      void'(sb.pop_front());
    end else begin
      chk("inst0", ifc.instqueue_decoder_inst_out, 0);
      chk("pc0", ifc.instqueue_decoder_pc_out, 0);
    end
    if (rdy) begin
      if (ifc.rob_instqueue_rst_in ||
          ifc.decoder_instqueue_rst_in)
        sb.delete();
      else if (ifc.if_instqueue_en_in && !full_pre)
        sb.push_back({ifc.if_instqueue_inst_in,
                      ifc.if_instqueue_pc_in});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] inst,
                      input logic [31:0] pc);
    ifc.if_instqueue_en_in   = 1'b1;
    ifc.if_instqueue_inst_in = inst;
    ifc.if_instqueue_pc_in   = pc;
    cyc();
    ifc.if_instqueue_en_in   = 1'b0;
  endtask

  task automatic drain();
    ifc.dispatcher_instqueue_stall_in = 1'b0;
    for (int g = 0; g < 64 && sb.size() != 0; g++) cyc();
    chk("drain", sb.size(), 0);
    cyc();
    chk("empty_cnt", ifc.instqueue_count_out, 0);
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    ifc.if_instqueue_en_in            = 1'b0;
    ifc.if_instqueue_inst_in          = '0;
    ifc.if_instqueue_pc_in            = '0;
    ifc.dispatcher_instqueue_stall_in = 1'b0;
    ifc.decoder_instqueue_rst_in      = 1'b0;
    ifc.rob_instqueue_rst_in          = 1'b0;
    #12;
    chk("rst_en", ifc.instqueue_decoder_en_out, 0);
    chk("rst_cnt", ifc.instqueue_count_out, 0);
    chk("rst_full", ifc.instqueue_if_full_out, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // In-order stream, no stall
    for (int i = 0; i < 8; i++) push(32'h13, 32'(i * 4));
    drain();

    // Fill with stall, overflow push dropped
    ifc.dispatcher_instqueue_stall_in = 1'b1;
    for (int i = 0; i < 16; i++)
      push(32'h13, 32'h200 + 32'(i * 4));
    chk("full16", ifc.instqueue_if_full_out, 1);
    chk("cnt16", ifc.instqueue_count_out, 16);
    push(32'h13, 32'h40);
    chk("cnt_ovf", ifc.instqueue_count_out, 16);
    pops = 0;
    drain();
    chk("pops16", pops, 16);

    // Full: push and pop same cycle -> push dropped
    ifc.dispatcher_instqueue_stall_in = 1'b1;
    for (int i = 0; i < 16; i++)
      push(32'h13, 32'h300 + 32'(i * 4));
    ifc.dispatcher_instqueue_stall_in = 1'b0;
    push(32'h13, 32'h44);
    chk("cnt15", ifc.instqueue_count_out, 15);
    drain();

    // 40 entries with random stalls: pointers wrap
    begin
      int k = 0;
      for (int g = 0; g < 400 && k < 40; g++) begin
        ifc.dispatcher_instqueue_stall_in =
          ($urandom_range(0, 2) == 0);
        if (sb.size() < DEPTH) begin
          push(32'h1000_0000 + 32'(k), 32'h1000 + 32'(k*4));
          k++;
        end else cyc();
      end
      chk("wrap_k", k, 40);
    end
    drain();

    // Decoder JAL flush: head still consumed
    ifc.dispatcher_instqueue_stall_in = 1'b1;
    push(32'h0080006F, 32'h100);
    for (int i = 1; i < 5; i++)
      push(32'h13, 32'h100 + 32'(i * 4));
    ifc.dispatcher_instqueue_stall_in = 1'b0;
    ifc.decoder_instqueue_rst_in = 1'b1;
    pops = 0;
    push(32'h13, 32'h500);
    ifc.decoder_instqueue_rst_in = 1'b0;
    chk("jal_pop", pops, 1);
    chk("jal_cnt", ifc.instqueue_count_out, 0);
    cyc();
    chk("jal_en", pops, 1);

    // ROB flush: no pop that cycle
    ifc.dispatcher_instqueue_stall_in = 1'b1;
    for (int i = 0; i < 6; i++)
      push(32'h13, 32'h600 + 32'(i * 4));
    ifc.dispatcher_instqueue_stall_in = 1'b0;
    ifc.rob_instqueue_rst_in = 1'b1;
    pops = 0;
    push(32'h13, 32'h700);
    ifc.rob_instqueue_rst_in = 1'b0;
    chk("rob_pop", pops, 0);
    chk("rob_cnt", ifc.instqueue_count_out, 0);

    // rdy low: everything holds
    ifc.dispatcher_instqueue_stall_in = 1'b1;
    for (int i = 0; i < 3; i++)
      push(32'h13, 32'h800 + 32'(i * 4));
    rdy = 1'b0;
    ifc.dispatcher_instqueue_stall_in = 1'b0;
    for (int i = 0; i < 3; i++)
      push(32'h13, 32'h900 + 32'(i * 4));
    chk("rdy_cnt", ifc.instqueue_count_out, 3);
    rdy = 1'b1;
    cyc();

    // Async reset mid-stream
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_en", ifc.instqueue_decoder_en_out, 0);
    chk("mrst_cnt", ifc.instqueue_count_out, 0);
    chk("mrst_pc", ifc.instqueue_decoder_pc_out, 0);
    chk("mrst_inst", ifc.instqueue_decoder_inst_out, 0);
    chk("mrst_full", ifc.instqueue_if_full_out, 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(32'h13, 32'hA00);
    drain();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
